// File: rtl/rf_stream_port.sv
// rf_stream_port: moves a block of 1..8 words between a valid/ready stream
// and an 8-entry register file. LOAD writes incoming stream words into
// consecutive RF addresses; DUMP reads consecutive RF addresses out onto the
// output stream. The address pointer wraps modulo 8.
module rf_stream_port #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [2:0]   cmd_base,
  input  logic [2:0]   cmd_count,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [2:0]   rf_addr_dest,
  output logic [W-1:0] rf_data_in,
  output logic         rf_wen,
  output logic         rf_wr,
  output logic [2:0]   rf_addr_src,
  input  logic [W-1:0] rf_src,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_DUMP_FETCH = 3'd2,
    S_DUMP_SEND  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_ptr;
  logic [3:0]     r_remaining;
  logic [W-1:0]   r_out_data;

  logic           w_accept;
  logic           w_load_hs;
  logic           w_dump_hs;
  logic           w_last_word;
  logic [3:0]     w_count;

  // A count field of zero encodes a full block of eight words.
  assign w_count     = (cmd_count == 3'd0) ? 4'd8 : {1'b0, cmd_count};
  assign w_last_word = (r_remaining == 4'd1);

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state handshake/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_hs   = 1'b0;
    w_dump_hs   = 1'b0;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = cmd_op ? S_DUMP_FETCH : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load_hs = 1'b1;
          if (w_last_word) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DUMP_FETCH: begin
        // RF read data is captured this cycle; the word is offered next cycle.
        w_state_nxt = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        out_valid = 1'b1;
        out_last  = w_last_word;
        if (out_ready) begin
          w_dump_hs   = 1'b1;
          w_state_nxt = w_last_word ? S_DONE : S_DUMP_FETCH;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pointer and word counter: loaded on accept, stepped on every transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= 3'd0;
      r_remaining <= 4'd0;
    end else if (w_accept) begin
      r_ptr       <= cmd_base;
      r_remaining <= w_count;
    end else if (w_load_hs || w_dump_hs) begin
      r_ptr       <= r_ptr + 3'd1;
      r_remaining <= r_remaining - 4'd1;
    end
  end

  // Output word register: sampled from the RF only in DUMP_FETCH so it holds
  // steady for as long as the consumer stalls in DUMP_SEND.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_data <= '0;
    end else if (r_state == S_DUMP_FETCH) begin
      r_out_data <= rf_src;
    end
  end

  assign out_data     = r_out_data;
  assign rf_wen       = w_load_hs;
  assign rf_wr        = w_load_hs;
  assign rf_addr_dest = r_ptr;
  assign rf_data_in   = in_data;
  assign rf_addr_src  = r_ptr;

endmodule

// File: tb/tb_rf_stream_port.sv
// Directed bench for rf_stream_port: drives LOAD/DUMP commands against a small
// 8-entry register file and checks stream, RF and status behaviour.
module tb_rf_stream_port;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [2:0]  cmd_base;
  logic [2:0]  cmd_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  rf_addr_dest;
  logic [31:0] rf_data_in;
  logic        rf_wen;
  logic        rf_wr;
  logic [2:0]  rf_addr_src;
  logic [31:0] rf_src;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;
  int done_cnt;

  logic [31:0] rf [8];

  rf_stream_port #(.W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_base     (cmd_base),
    .cmd_count    (cmd_count),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .rf_addr_dest (rf_addr_dest),
    .rf_data_in   (rf_data_in),
    .rf_wen       (rf_wen),
    .rf_wr        (rf_wr),
    .rf_addr_src  (rf_addr_src),
    .rf_src       (rf_src),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file attached to the port
  always @(posedge clk) begin
    if (rf_wen) rf[rf_addr_dest] <= rf_data_in;
  end
  assign rf_src = rf[rf_addr_src];

  always @(posedge clk) begin
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge; returns 1 time unit after the accept edge.
  task automatic send_cmd(input logic op, input logic [2:0] base, input logic [2:0] cnt);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_count = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // LOAD with in_valid following vpat (bit c = cycle c); nwr words expected.
  task automatic load_run(input logic [2:0] base, input logic [2:0] cnt, input int nwr,
                          input logic [31:0] w0, input logic [7:0] vpat);
    int k;
    int d0;
    logic [2:0] a;
    k  = 0;
    d0 = done_cnt;
    send_cmd(1'b0, base, cnt);
    for (int c = 0; c < 8; c++) begin
      if (k >= nwr) break;
      in_valid = vpat[c];
      in_data  = w0 + k;
      a        = base + k[2:0];
      @(negedge clk);
      chk("ld_inrdy", {31'd0, in_ready}, 32'd1);
      chk("ld_wen", {31'd0, rf_wen}, {31'd0, vpat[c]});
      chk("ld_wr", {31'd0, rf_wr}, {31'd0, vpat[c]});
      chk("ld_addr", {29'd0, rf_addr_dest}, {29'd0, a});
      if (vpat[c]) begin
        chk("ld_data", rf_data_in, w0 + k);
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ld_done", {31'd0, done}, 32'd1);
    chk("ld_busy_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_done_off", {31'd0, done}, 32'd0);
    chk("ld_busy_off", {31'd0, busy}, 32'd0);
    chk("ld_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    chk("ld_done_cnt", done_cnt - d0, 32'd1);
  endtask

  // DUMP of nw words expected as w0+i from address base+i; stall 5 cycles on stall_idx.
  task automatic dump_run(input logic [2:0] base, input logic [2:0] cnt, input int nw,
                          input logic [31:0] w0, input int stall_idx);
    int d0;
    logic [2:0] a;
    d0 = done_cnt;
    out_ready = 1'b1;
    send_cmd(1'b1, base, cnt);
    for (int i = 0; i < nw; i++) begin
      a = base + i[2:0];
      @(negedge clk);
      chk("dp_fetch_vld", {31'd0, out_valid}, 32'd0);
      chk("dp_fetch_busy", {31'd0, busy}, 32'd1);
      if (i == stall_idx) out_ready = 1'b0;
      @(posedge clk); #1;
      if (i == stall_idx) begin
        repeat (5) begin
          @(negedge clk);
          chk("st_vld", {31'd0, out_valid}, 32'd1);
          chk("st_data", out_data, w0 + i);
          chk("st_ptr", {29'd0, rf_addr_src}, {29'd0, a});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      chk("dp_vld", {31'd0, out_valid}, 32'd1);
      chk("dp_data", out_data, w0 + i);
      chk("dp_last", {31'd0, out_last}, (i == nw - 1) ? 32'd1 : 32'd0);
      chk("dp_done_low", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("dp_done", {31'd0, done}, 32'd1);
    chk("dp_vld_done", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dp_busy_off", {31'd0, busy}, 32'd0);
    chk("dp_done_cnt", done_cnt - d0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    n_vec     = 0;
    n_err     = 0;
    done_cnt  = 0;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_base  = 3'd0;
    cmd_count = 3'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("rst_src", {29'd0, rf_addr_src}, 32'd0);
    resetn = 1'b1;

    // Stray in_valid/out_ready in IDLE are ignored
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_wen", {31'd0, rf_wen}, 32'd0);
    chk("idle_vld", {31'd0, out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // LOAD base 2 count 3: 0xA,0xB,0xC
    load_run(3'd2, 3'd3, 3, 32'hA, 8'hFF);
    chk("rf2", rf[2], 32'hA);
    chk("rf3", rf[3], 32'hB);
    chk("rf4", rf[4], 32'hC);

    // LOAD base 6 count 4: 1..4 wraps 6,7,0,1
    load_run(3'd6, 3'd4, 4, 32'd1, 8'hFF);
    chk("rf6", rf[6], 32'd1);
    chk("rf7", rf[7], 32'd2);
    chk("rf0", rf[0], 32'd3);
    chk("rf1", rf[1], 32'd4);

    // Preload RF[i] = 0x100+i with a full 8-word LOAD
    load_run(3'd0, 3'd0, 8, 32'h100, 8'hFF);
    chk("pre_rf0", rf[0], 32'h100);
    chk("pre_rf7", rf[7], 32'h107);

    // DUMP base 0 count 0 -> 8 words
    dump_run(3'd0, 3'd0, 8, 32'h100, -1);

    // DUMP base 0 count 4 with a 5-cycle stall on word 2
    dump_run(3'd0, 3'd4, 4, 32'h100, 2);

    // LOAD with in_valid 1,0,1: writes 0x55,0x56 to 5,6 only
    load_run(3'd5, 3'd2, 2, 32'h55, 8'b0000_0101);
    chk("tg_rf5", rf[5], 32'h55);
    chk("tg_rf6", rf[6], 32'h56);
    chk("tg_rf7", rf[7], 32'h107);

    // Reset aborts a LOAD after 2 of 5 words
    d0 = done_cnt;
    send_cmd(1'b0, 3'd0, 3'd5);
    in_valid = 1'b1;
    in_data  = 32'h201;
    @(posedge clk); #1;
    in_data  = 32'h202;
    @(posedge clk); #1;
    in_data  = 32'h203;
    resetn   = 1'b0;
    @(negedge clk);
    chk("ab_wen", {31'd0, rf_wen}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    chk("ab_inrdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    resetn   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_done_cnt", done_cnt - d0, 32'd0);
    chk("ab_rf0", rf[0], 32'h201);
    chk("ab_rf1", rf[1], 32'h202);
    chk("ab_rf2", rf[2], 32'h102);

    // A normal command after the abort
    dump_run(3'd0, 3'd2, 2, 32'h201, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
